// File: rtl/smi_master_pkg.sv
// rtl/smi_master_pkg.sv - shared SMI master states, default timing and bus width
package smi_master_pkg;

   localparam int SMI_DATA_W         = 8;
   localparam int DEF_SETUP_CYCLES   = 2;
   localparam int DEF_STROBE_CYCLES  = 4;
   localparam int DEF_HOLD_CYCLES    = 2;
   localparam int DEF_PACE_CYCLES    = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_PACE
   } smi_state_t;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/smi_phase_timer.sv
// rtl/smi_phase_timer.sv - loadable down-counter with zero flag, stops at zero
module smi_phase_timer #(
   parameter int W = 3
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge CLK) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/smi_master.sv
// rtl/smi_master.sv - SMI bus initiator with programmable setup/strobe/hold/pace timing
module smi_master
   import smi_master_pkg::*;
#(
   parameter int ADDR_W        = 6,
   parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
   parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int PACE_CYCLES   = DEF_PACE_CYCLES
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [SMI_DATA_W-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [SMI_DATA_W-1:0] rsp_rdata,
   output logic                  busy,
   output logic [ADDR_W-1:0]     smi_addr,
   output logic                  smi_oe_n,
   output logic                  smi_we_n,
   inout  logic [SMI_DATA_W-1:0] smi_data
);

   localparam int MAX_PHASE = max_of(max_of(SETUP_CYCLES, STROBE_CYCLES),
                                     max_of(HOLD_CYCLES, PACE_CYCLES));
   localparam int CNT_W     = $clog2(MAX_PHASE) + 1;

   smi_state_t              state_q, state_d;
   logic                    tmr_load;
   logic [CNT_W-1:0]        tmr_val;
   logic [CNT_W-1:0]        tmr_count;
   logic                    tmr_zero;
   logic                    wr_q;
   logic                    wr_eff;
   logic                    accept;
   logic                    read_done;
   logic                    drive_en;
   logic [SMI_DATA_W-1:0]   wdata_q;

   smi_phase_timer #(.W(CNT_W)) u_timer (
      .CLK      (CLK),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .count    (tmr_count),
      .zero     (tmr_zero)
   );

   assign accept    = (state_q == ST_IDLE) && cmd_valid;
   assign wr_eff    = (state_q == ST_IDLE) ? cmd_write : wr_q;
   assign read_done = (state_q == ST_STROBE) && tmr_zero && !wr_q;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         ST_IDLE:   if (cmd_valid) state_d = ST_SETUP;
         ST_SETUP:  if (tmr_zero)  state_d = ST_STROBE;
         ST_STROBE: if (tmr_zero)  state_d = ST_HOLD;
         ST_HOLD:   if (tmr_zero)  state_d = (PACE_CYCLES > 0) ? ST_PACE : ST_IDLE;
         ST_PACE:   if (tmr_zero)  state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
      // Each phase lasts N cycles: load N-1 on entry, leave when the count reaches zero.
      if (state_d != state_q) begin
         tmr_load = 1'b1;
         case (state_d)
            ST_SETUP:  tmr_val = CNT_W'(SETUP_CYCLES - 1);
            ST_STROBE: tmr_val = CNT_W'(STROBE_CYCLES - 1);
            ST_HOLD:   tmr_val = CNT_W'(HOLD_CYCLES - 1);
            ST_PACE:   tmr_val = (PACE_CYCLES > 0) ? CNT_W'(PACE_CYCLES - 1) : '0;
            default:   tmr_val = '0;
         endcase
      end
   end

   // Bus-facing outputs are registered from the next state so they line up with the phases.
   always_ff @(posedge CLK) begin
      if (reset) begin
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         smi_addr  <= '0;
         smi_oe_n  <= 1'b1;
         smi_we_n  <= 1'b1;
         drive_en  <= 1'b0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
      end else begin
         cmd_ready <= (state_d == ST_IDLE);
         busy      <= (state_d != ST_IDLE);
         smi_we_n  <= !((state_d == ST_STROBE) && wr_eff);
         smi_oe_n  <= !((state_d == ST_STROBE) && !wr_eff);
         drive_en  <= wr_eff && (state_d inside {ST_SETUP, ST_STROBE, ST_HOLD});
         rsp_valid <= read_done;
         if (read_done) begin
            rsp_rdata <= smi_data;
         end
         if (accept) begin
            wr_q     <= cmd_write;
            smi_addr <= cmd_addr;
            wdata_q  <= cmd_wdata;
         end
      end
   end

   assign smi_data = drive_en ? wdata_q : {SMI_DATA_W{1'bz}};

endmodule

// File: tb/tb_smi_master.sv
// tb/tb_smi_master.sv - scoreboard bench for smi_master (default timing and S=T=H=1,P=0)
module tb_smi_master;

   logic       CLK = 1'b0;
   logic       reset;
   logic       v;
   logic       sel;
   logic       cmd_write;
   logic [5:0] cmd_addr;
   logic [7:0] cmd_wdata;

   logic       d_ready, d_rv, d_busy, d_oe_n, d_we_n;
   logic [7:0] d_rdata;
   logic [5:0] d_addr;
   wire  [7:0] smi_data;
   logic       f_ready, f_rv, f_busy, f_oe_n, f_we_n;
   logic [7:0] f_rdata;
   logic [5:0] f_addr;
   wire  [7:0] f_smi_data;

   always #5 CLK = ~CLK;

   smi_master dut (
      .CLK(CLK), .reset(reset), .cmd_valid(v & ~sel), .cmd_ready(d_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(d_rv), .rsp_rdata(d_rdata), .busy(d_busy), .smi_addr(d_addr),
      .smi_oe_n(d_oe_n), .smi_we_n(d_we_n), .smi_data(smi_data)
   );

   smi_master #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1), .PACE_CYCLES(0)) dut_fast (
      .CLK(CLK), .reset(reset), .cmd_valid(v & sel), .cmd_ready(f_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(f_rv), .rsp_rdata(f_rdata), .busy(f_busy), .smi_addr(f_addr),
      .smi_oe_n(f_oe_n), .smi_we_n(f_we_n), .smi_data(f_smi_data)
   );

   // Peripheral model: drives only while OE is low; each completed read flips bit 5.
   logic [7:0] mem [0:63];
   logic       oe_prev, f_oe_prev;
   assign smi_data   = d_oe_n ? 8'hzz : mem[d_addr];
   assign f_smi_data = f_oe_n ? 8'hzz : mem[f_addr];

   always @(posedge CLK) begin
      oe_prev   <= d_oe_n;
      f_oe_prev <= f_oe_n;
      if (reset) begin
         for (int i = 0; i < 64; i++) mem[i] <= (i == 1) ? 8'h65 : 8'h00;
      end else begin
         if (!d_we_n) mem[d_addr] <= smi_data;
         if (d_oe_n && !oe_prev) mem[d_addr] <= mem[d_addr] ^ 8'h20;
         if (!f_we_n) mem[f_addr] <= f_smi_data;
         if (f_oe_n && !f_oe_prev) mem[f_addr] <= mem[f_addr] ^ 8'h20;
      end
   end

   wire       m_ready = sel ? f_ready : d_ready;
   wire       m_rv    = sel ? f_rv    : d_rv;
   wire       m_busy  = sel ? f_busy  : d_busy;
   wire       m_oe_n  = sel ? f_oe_n  : d_oe_n;
   wire       m_we_n  = sel ? f_we_n  : d_we_n;
   wire [7:0] m_rdata = sel ? f_rdata : d_rdata;
   wire [5:0] m_addr  = sel ? f_addr  : d_addr;
   wire [7:0] m_data  = sel ? f_smi_data : smi_data;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int c0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } sb_t;
   sb_t sb[$];

   always @(negedge CLK) begin
      if (!reset && m_rv) begin
         if (sb.size() == 0) begin
            check_val("rsp_unexpected", 1, 0);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check_val("rsp_rdata", m_rdata, e.data);
            check_val("rsp_cycle", cyc, e.cyc);
         end
      end
   end

   logic [63:0] oe_low, we_low, rdy_v, busy_v, rv_v, acc_v, idle_v, addr_v, data_v;

   task automatic start_cmd(input logic w, input logic [5:0] a, input logic [7:0] d);
      int n = 0;
      @(posedge CLK); #1;
      while (!m_ready && n < 50) begin
         @(posedge CLK); #1;
         n++;
      end
      if (n >= 50) check_val("ready_timeout", 0, 1);
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      v         = 1'b1;
      c0        = cyc;
   endtask

   task automatic capture(input int n, input int drop_at, input int switch_at, input int rst_at,
                          input logic [5:0] sw_addr);
      {oe_low, we_low, rdy_v, busy_v, rv_v, acc_v, idle_v, addr_v, data_v} = '0;
      for (int k = 0; k < n; k++) begin
         @(negedge CLK);
         oe_low[k] = !m_oe_n;
         we_low[k] = !m_we_n;
         rdy_v[k]  = m_ready;
         busy_v[k] = m_busy;
         rv_v[k]   = m_rv;
         acc_v[k]  = m_ready && v;
         idle_v[k] = (m_data === 8'hzz) || (m_data == 8'h00);
         addr_v[k] = (m_addr == cmd_addr);
         data_v[k] = (m_data == cmd_wdata);
         @(posedge CLK); #1;
         if (k == drop_at) v = 1'b0;
         if (k == switch_at) begin
            cmd_write = 1'b0;
            cmd_addr  = sw_addr;
            cmd_wdata = 8'hA5;
         end
         if (k + 1 == rst_at) reset = 1'b1;
         if (k == rst_at) reset = 1'b0;
      end
   endtask

   int last_we, first_oe;

   initial begin
      reset = 1'b1; v = 1'b0; sel = 1'b0;
      cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      repeat (3) @(posedge CLK);
      #1 reset = 1'b0;
      @(negedge CLK);
      check_val("rst_cmd_ready", d_ready, 1);
      check_val("rst_busy", d_busy, 0);
      check_val("rst_rsp_valid", d_rv, 0);
      check_val("rst_rsp_rdata", d_rdata, 0);
      check_val("rst_smi_addr", d_addr, 0);
      check_val("rst_oe_n", d_oe_n, 1);
      check_val("rst_we_n", d_we_n, 1);

      // Single write
      start_cmd(1'b1, 6'h03, 8'h45);
      capture(11, 0, -1, -1, 6'h0);
      check_val("wr_we_low", we_low[10:0], 11'h078);
      check_val("wr_oe_low", oe_low[10:0], 11'h000);
      check_val("wr_addr_data", addr_v[10:0] & data_v[10:0], 11'h1FE);
      check_val("wr_ready", rdy_v[10:0], 11'h401);
      check_val("wr_busy", busy_v[10:0], 11'h3FE);

      // Single read
      start_cmd(1'b0, 6'h01, 8'hA5);
      sb.push_back('{8'h65, c0 + 7});
      capture(11, 0, -1, -1, 6'h0);
      check_val("rd_oe_low", oe_low[10:0], 11'h078);
      check_val("rd_we_low", we_low[10:0], 11'h000);
      check_val("rd_rsp_valid", rv_v[10:0], 11'h080);
      check_val("rd_bus_released", idle_v[10:0] | oe_low[10:0], 11'h7FF);

      // Back-to-back write then read with cmd_valid held
      start_cmd(1'b1, 6'h04, 8'h5A);
      sb.push_back('{8'h5A, c0 + 17});
      capture(21, 10, 0, -1, 6'h04);
      check_val("b2b_accepts", acc_v[20:0], 21'h000401);
      check_val("b2b_overlap", oe_low[20:0] & we_low[20:0], 21'h0);
      last_we = -1; first_oe = -1;
      for (int k = 0; k < 21; k++) begin
         if (we_low[k]) last_we = k;
         if (oe_low[k] && first_oe < 0) first_oe = k;
      end
      check_val("b2b_gap_ok", (first_oe - last_we - 1) >= 3, 1);

      // Reset during cycle 4 of a read
      start_cmd(1'b0, 6'h01, 8'hA5);
      capture(9, 0, -1, 4, 6'h0);
      check_val("abort_strobe_was_low", oe_low[4], 1);
      check_val("abort_oe_low_c5", oe_low[5], 0);
      check_val("abort_busy_c5", busy_v[5], 0);
      check_val("abort_bus_idle_c5", idle_v[5], 1);
      check_val("abort_ready_c5", rdy_v[5], 1);
      check_val("abort_no_rsp", rv_v[8:0], 9'h0);

      // Minimum timing instance
      sel = 1'b1;
      start_cmd(1'b0, 6'h01, 8'hA5);
      sb.push_back('{8'h65, c0 + 3});
      capture(5, 0, -1, -1, 6'h0);
      check_val("fast_rd_ready", rdy_v[4:0], 5'h11);
      check_val("fast_rd_oe_low", oe_low[4:0], 5'h04);
      check_val("fast_rd_rsp", rv_v[4:0], 5'h08);
      start_cmd(1'b1, 6'h07, 8'h33);
      capture(5, 0, -1, -1, 6'h0);
      check_val("fast_wr_ready", rdy_v[4:0], 5'h11);
      check_val("fast_wr_we_low", we_low[4:0], 5'h04);
      sel = 1'b0;

      // Loopback: write then two reads through the peripheral model
      start_cmd(1'b1, 6'h02, 8'h45);
      capture(10, 0, -1, -1, 6'h0);
      start_cmd(1'b0, 6'h02, 8'hA5);
      sb.push_back('{8'h45, c0 + 7});
      capture(10, 0, -1, -1, 6'h0);
      start_cmd(1'b0, 6'h02, 8'hA5);
      sb.push_back('{8'h65, c0 + 7});
      capture(10, 0, -1, -1, 6'h0);

      repeat (3) @(negedge CLK);
      check_val("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
